// File: rtl/hp_pkg.sv
// Shared types, widths and saturating arithmetic for the hit-point controller.
package hp_pkg;

    localparam int HP_W  = 16;
    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } hp_state_e;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (b >= a) ? '0 : (a - b);
    endfunction

    // Sum is computed one bit wider so the ceiling compare cannot wrap.
    function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b,
                                                input logic [HP_W-1:0] ceil);
        logic [HP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, ceil}) ? ceil : s[HP_W-1:0];
    endfunction

endpackage

// File: rtl/hp_drain.sv
// Displayed-HP register: snaps up to the target, drains down at most DRAIN_STEP per frame.
module hp_drain
    import hp_pkg::*;
#(
    parameter int MAX_HP     = 20,
    parameter int DRAIN_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_restart,
    input  logic            i_frame_tick,
    input  logic [HP_W-1:0] i_target,
    output logic [HP_W-1:0] o_disp,
    output logic            o_busy
);

    localparam logic [HP_W-1:0] LP_MAX  = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] LP_STEP = HP_W'(DRAIN_STEP);

    logic [HP_W-1:0] r_disp;
    logic [HP_W-1:0] w_disp_nxt;
    logic [HP_W-1:0] w_gap;
    logic [HP_W-1:0] w_step;

    // w_gap is only consumed when r_disp > i_target, so the wrap case never matters.
    always_comb begin
        w_gap      = r_disp - i_target;
        w_step     = (w_gap < LP_STEP) ? w_gap : LP_STEP;
        w_disp_nxt = r_disp;
        if (i_restart) begin
            w_disp_nxt = LP_MAX;
        end else if (r_disp < i_target) begin
            w_disp_nxt = i_target;
        end else if ((r_disp > i_target) && i_frame_tick) begin
            w_disp_nxt = r_disp - w_step;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp <= LP_MAX;
        end else begin
            r_disp <= w_disp_nxt;
        end
    end

    assign o_disp = r_disp;
    assign o_busy = (r_disp != i_target);

endmodule

// File: rtl/hp_controller.sv
// Player hit-point state: damage/heal, frame-counted invulnerability, death, smoothed display value.
//   state     | meaning
//   ST_ALIVE  | hits and heals accepted
//   ST_INVULN | hits ignored, heals accepted, iframe counter runs down on frame ticks
//   ST_DEAD   | true HP is 0, events ignored until restart
module hp_controller
    import hp_pkg::*;
#(
    parameter int MAX_HP        = 20,
    parameter int IFRAME_FRAMES = 60,
    parameter int DRAIN_STEP    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_tick,
    input  logic             i_hit,
    input  logic [AMT_W-1:0] i_hit_dmg,
    input  logic             i_heal,
    input  logic [AMT_W-1:0] i_heal_amt,
    input  logic             i_restart,
    output logic [HP_W-1:0]  o_total_hp,
    output logic [HP_W-1:0]  o_remain_hp,
    output logic [HP_W-1:0]  o_true_hp,
    output logic             o_invuln,
    output logic             o_dead,
    output logic             o_drain_busy
);

    localparam int              CNT_W  = $clog2(IFRAME_FRAMES + 1);
    localparam logic [HP_W-1:0]  LP_MAX = HP_W'(MAX_HP);
    localparam logic [CNT_W-1:0] LP_IFR = CNT_W'(IFRAME_FRAMES);
    localparam logic [CNT_W-1:0] LP_TC  = CNT_W'(1);

    hp_state_e        r_state, w_state_nxt;
    logic [HP_W-1:0]  r_true_hp, w_true_nxt;
    logic [CNT_W-1:0] r_iframe_cnt, w_cnt_nxt;

    logic [HP_W-1:0]  w_hit_hp;
    logic [HP_W-1:0]  w_heal_hp;
    logic             w_hit_valid;

    assign w_hit_hp    = sat_sub(r_true_hp, {{(HP_W-AMT_W){1'b0}}, i_hit_dmg});
    assign w_heal_hp   = sat_add(r_true_hp, {{(HP_W-AMT_W){1'b0}}, i_heal_amt}, LP_MAX);
    assign w_hit_valid = i_hit && (i_hit_dmg != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_ALIVE;
            r_true_hp    <= LP_MAX;
            r_iframe_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_true_hp    <= w_true_nxt;
            r_iframe_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_true_nxt  = r_true_hp;
        w_cnt_nxt   = r_iframe_cnt;
        if (i_restart) begin
            w_state_nxt = ST_ALIVE;
            w_true_nxt  = LP_MAX;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_ALIVE: begin
                    // A real hit wins over a same-cycle heal.
                    if (w_hit_valid) begin
                        w_true_nxt = w_hit_hp;
                        if (w_hit_hp == '0) begin
                            w_state_nxt = ST_DEAD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_INVULN;
                            w_cnt_nxt   = LP_IFR;
                        end
                    end else if (i_heal) begin
                        w_true_nxt = w_heal_hp;
                    end
                end
                ST_INVULN: begin
                    if (i_heal) begin
                        w_true_nxt = w_heal_hp;
                    end
                    if (i_frame_tick) begin
                        if (r_iframe_cnt == LP_TC) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_ALIVE;
                        end else begin
                            w_cnt_nxt = r_iframe_cnt - LP_TC;
                        end
                    end
                end
                ST_DEAD: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_ALIVE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    hp_drain #(
        .MAX_HP     (MAX_HP),
        .DRAIN_STEP (DRAIN_STEP)
    ) u_drain (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_restart    (i_restart),
        .i_frame_tick (i_frame_tick),
        .i_target     (r_true_hp),
        .o_disp       (o_remain_hp),
        .o_busy       (o_drain_busy)
    );

    assign o_total_hp = LP_MAX;
    assign o_true_hp  = r_true_hp;
    assign o_invuln   = (r_state == ST_INVULN);
    assign o_dead     = (r_state == ST_DEAD);

endmodule

// File: tb/tb_hp_controller.sv
// Scenario bench for hp_controller: reference model feeds a per-cycle scoreboard, tasks add targeted checks.
module tb_hp_controller;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_frame_tick;
    logic        i_hit;
    logic [7:0]  i_hit_dmg;
    logic        i_heal;
    logic [7:0]  i_heal_amt;
    logic        i_restart;
    logic [15:0] o_total_hp;
    logic [15:0] o_remain_hp;
    logic [15:0] o_true_hp;
    logic        o_invuln;
    logic        o_dead;
    logic        o_drain_busy;

    localparam int MAX  = 20;
    localparam int IFR  = 60;
    localparam int STEP = 1;

    hp_controller #(.MAX_HP(MAX), .IFRAME_FRAMES(IFR), .DRAIN_STEP(STEP)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .i_hit        (i_hit),
        .i_hit_dmg    (i_hit_dmg),
        .i_heal       (i_heal),
        .i_heal_amt   (i_heal_amt),
        .i_restart    (i_restart),
        .o_total_hp   (o_total_hp),
        .o_remain_hp  (o_remain_hp),
        .o_true_hp    (o_true_hp),
        .o_invuln     (o_invuln),
        .o_dead       (o_dead),
        .o_drain_busy (o_drain_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int true_hp;
        int disp_hp;
        bit invuln;
        bit dead;
        bit busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0 alive, 1 invuln, 2 dead
    int m_true, m_disp, m_st, m_cnt;

    task automatic model_reset();
        m_true = MAX; m_disp = MAX; m_st = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit hit, input int dmg, input bit heal, input int amt,
                              input bit tick, input bit rst);
        int nt, nd, ns, nc, gap;
        exp_t e;
        nt = m_true; nd = m_disp; ns = m_st; nc = m_cnt;
        if (rst) begin
            nt = MAX; nd = MAX; ns = 0; nc = 0;
        end else begin
            if (m_disp < m_true) nd = m_true;
            else if (m_disp > m_true && tick) begin
                gap = m_disp - m_true;
                nd  = m_disp - ((gap < STEP) ? gap : STEP);
            end
            if (m_st == 0) begin
                if (hit && dmg > 0) begin
                    nt = (m_true > dmg) ? m_true - dmg : 0;
                    if (nt == 0) begin ns = 2; nc = 0; end
                    else begin ns = 1; nc = IFR; end
                end else if (heal) begin
                    nt = (m_true + amt > MAX) ? MAX : m_true + amt;
                end
            end else if (m_st == 1) begin
                if (heal) nt = (m_true + amt > MAX) ? MAX : m_true + amt;
                if (tick) begin
                    if (m_cnt == 1) begin nc = 0; ns = 0; end
                    else nc = m_cnt - 1;
                end
            end else begin
                nc = 0;
            end
        end
        m_true = nt; m_disp = nd; m_st = ns; m_cnt = nc;
        e.true_hp = nt; e.disp_hp = nd; e.invuln = (ns == 1); e.dead = (ns == 2); e.busy = (nd != nt);
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the model's prediction is queued before the edge and retired after it.
    task automatic cycle(input bit hit, input int dmg, input bit heal, input int amt,
                         input bit tick, input bit rst);
        exp_t e;
        @(negedge i_clk);
        i_hit = hit; i_hit_dmg = 8'(dmg); i_heal = heal; i_heal_amt = 8'(amt);
        i_frame_tick = tick; i_restart = rst;
        model_step(hit, dmg, heal, amt, tick, rst);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty no expectation queued at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (o_true_hp !== 16'(e.true_hp) || o_remain_hp !== 16'(e.disp_hp) ||
                o_invuln !== e.invuln || o_dead !== e.dead || o_drain_busy !== e.busy ||
                o_total_hp !== 16'(MAX)) begin
                n_fail++;
                $display("FAIL sb_cycle t=%0t got true=%0d disp=%0d inv=%0b dead=%0b busy=%0b total=%0d exp true=%0d disp=%0d inv=%0b dead=%0b busy=%0b total=%0d",
                         $time, o_true_hp, o_remain_hp, o_invuln, o_dead, o_drain_busy, o_total_hp,
                         e.true_hp, e.disp_hp, e.invuln, e.dead, e.busy, MAX);
            end
        end
        #1;
        i_hit = 1'b0; i_heal = 1'b0; i_frame_tick = 1'b0; i_restart = 1'b0;
        i_hit_dmg = '0; i_heal_amt = '0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_hit = 0; i_hit_dmg = 0; i_heal = 0; i_heal_amt = 0; i_frame_tick = 0; i_restart = 0;
        model_reset();
        #12;
        n_tests++;
        if (o_true_hp !== 16'd20 || o_remain_hp !== 16'd20 || o_total_hp !== 16'd20 ||
            o_invuln !== 1'b0 || o_dead !== 1'b0 || o_drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got true=%0d disp=%0d total=%0d inv=%0b dead=%0b busy=%0b exp 20 20 20 0 0 0",
                     o_true_hp, o_remain_hp, o_total_hp, o_invuln, o_dead, o_drain_busy);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_hit_drain();
        cycle(1, 5, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd15 || o_invuln !== 1'b1 || o_remain_hp !== 16'd20) begin
            n_fail++;
            $display("FAIL hit5 got true=%0d inv=%0b disp=%0d exp 15 1 20", o_true_hp, o_invuln, o_remain_hp);
        end
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            n_tests++;
            if (o_remain_hp !== 16'(20 - k)) begin
                n_fail++;
                $display("FAIL drain_step%0d got disp=%0d exp %0d", k, o_remain_hp, 20 - k);
            end
        end
        n_tests++;
        if (o_drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done got busy=%0b exp 0", o_drain_busy);
        end
    endtask

    task automatic test_iframes();
        cycle(1, 7, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd15) begin
            n_fail++;
            $display("FAIL invuln_ignore got true=%0d exp 15", o_true_hp);
        end
        ticks(54);
        n_tests++;
        if (o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL tick59 got inv=%0b exp 1", o_invuln);
        end
        ticks(1);
        n_tests++;
        if (o_invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL tick60 got inv=%0b exp 0", o_invuln);
        end
        cycle(1, 7, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd8 || o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL rehit got true=%0d inv=%0b exp 8 1", o_true_hp, o_invuln);
        end
    endtask

    task automatic test_death();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 17, 0, 0, 0, 0);
        ticks(60);
        n_tests++;
        if (o_true_hp !== 16'd3 || o_remain_hp !== 16'd3 || o_invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_death got true=%0d disp=%0d inv=%0b exp 3 3 0", o_true_hp, o_remain_hp, o_invuln);
        end
        cycle(1, 200, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd0 || o_dead !== 1'b1 || o_invuln !== 1'b0 || o_remain_hp !== 16'd3) begin
            n_fail++;
            $display("FAIL death got true=%0d dead=%0b inv=%0b disp=%0d exp 0 1 0 3",
                     o_true_hp, o_dead, o_invuln, o_remain_hp);
        end
        ticks(4);
        n_tests++;
        if (o_remain_hp !== 16'd0 || o_drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_drain got disp=%0d busy=%0b exp 0 0", o_remain_hp, o_drain_busy);
        end
        cycle(0, 0, 1, 10, 0, 0);
        cycle(1, 5, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd0 || o_dead !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_ignore got true=%0d dead=%0b exp 0 1", o_true_hp, o_dead);
        end
    endtask

    task automatic test_heal_sat();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 0);
        ticks(60);
        cycle(1, 4, 1, 9, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd14) begin
            n_fail++;
            $display("FAIL hit_heal_same got true=%0d exp 14", o_true_hp);
        end
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 0);
        ticks(60);
        cycle(0, 0, 1, 9, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd20) begin
            n_fail++;
            $display("FAIL heal_sat got true=%0d exp 20", o_true_hp);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (o_remain_hp !== 16'd20 || o_drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL heal_snap got disp=%0d busy=%0b exp 20 0", o_remain_hp, o_drain_busy);
        end
    endtask

    task automatic test_restart_dead();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 200, 0, 0, 0, 0);
        ticks(3);
        n_tests++;
        if (o_remain_hp !== 16'd17 || o_drain_busy !== 1'b1 || o_dead !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drain got disp=%0d busy=%0b dead=%0b exp 17 1 1", o_remain_hp, o_drain_busy, o_dead);
        end
        cycle(1, 9, 1, 3, 1, 1);
        n_tests++;
        if (o_true_hp !== 16'd20 || o_remain_hp !== 16'd20 || o_dead !== 1'b0 || o_invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL restart got true=%0d disp=%0d dead=%0b inv=%0b exp 20 20 0 0",
                     o_true_hp, o_remain_hp, o_dead, o_invuln);
        end
        cycle(1, 5, 0, 0, 1, 0);
        ticks(59);
        n_tests++;
        if (o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_tick got inv=%0b exp 1", o_invuln);
        end
        ticks(1);
        n_tests++;
        if (o_invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL entry_tick_end got inv=%0b exp 0", o_invuln);
        end
    endtask

    task automatic test_reset_async();
        cycle(1, 5, 0, 0, 0, 0);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (o_true_hp !== 16'd20 || o_remain_hp !== 16'd20 || o_invuln !== 1'b0 ||
            o_dead !== 1'b0 || o_drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got true=%0d disp=%0d inv=%0b dead=%0b busy=%0b exp 20 20 0 0 0",
                     o_true_hp, o_remain_hp, o_invuln, o_dead, o_drain_busy);
        end
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cycle(1, 4, 0, 0, 0, 0);
        n_tests++;
        if (o_true_hp !== 16'd16 || o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_hit got true=%0d inv=%0b exp 16 1", o_true_hp, o_invuln);
        end
    endtask

    initial begin
        test_reset();
        test_hit_drain();
        test_iframes();
        test_death();
        test_heal_sat();
        test_restart_dead();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
